inertial_integrator_cal: RTL and testbench
==========================================

// Module: inertial_integrator_cal
// PURPOSE
//   Parametrised successor of the pitch inertial integrator. Integrates offset-compensated
//   gyro rate and fuses accelerometer-derived pitch, as the existing block does.
//   Adds a power-up/on-demand calibration FSM that learns the rate offset by averaging
//   2^CAL_LOG2 samples, saturating accumulation, a fusion enable and an output valid strobe.
//   Sits between the inertial SPI interface and the balance controller.
// PARAMETERS
//   RT_W            16       width of ptch_rt, AZ, ptch, rt_offset
//   INT_W           27       integrator accumulator width; ptch = ptch_int[INT_W-1 -: RT_W]
//   CAL_LOG2        9        log2 of number of vld samples averaged during calibration
//   AZ_OFFSET       16'h00A0 fixed AZ offset subtracted before fusion
//   ACC_GAIN        377      AZ-to-pitch fudge factor (signed multiply)
//   ACC_SHIFT       13       arithmetic right shift applied to AZ product
//   FUSE_STEP       1024     leak magnitude added to/subtracted from ptch_int per vld
// PORTS
//   clk        in   1      clock
//   rst_n      in   1      reset, asynchronous, active-low
//   vld        in   1      one-cycle pulse: new ptch_rt/AZ valid
//   ptch_rt    in   RT_W   signed raw pitch rate
//   AZ         in   RT_W   signed raw Z acceleration
//   cal_req    in   1      level: restart calibration (held high = stay in CAL)
//   fuse_en    in   1      1 = apply accelerometer fusion, 0 = pure gyro integration
//   ptch       out  RT_W   signed fused pitch
//   ptch_vld   out  1      one-cycle pulse, cycle after a RUN-state vld
//   cal_done   out  1      high while in RUN
//   rt_offset  out  RT_W   learned signed rate offset
// BEHAVIOUR
//   Reset: state=CAL, ptch_int=0, cal_sum=0, cal_cnt=0, rt_offset=0, ptch_vld=0, cal_done=0.
//   CAL: each vld: cal_sum += sext(ptch_rt) (width RT_W+CAL_LOG2), cal_cnt++.
//     On vld with cal_cnt==2^CAL_LOG2-1: rt_offset<=(cal_sum+ptch_rt)>>>CAL_LOG2 (truncate
//     to RT_W), cal_sum/cal_cnt<=0, ptch_int<=0, state<=RUN; cal_done=1 from next cycle.
//     No ptch_vld pulses, ptch_int held at 0 in CAL.
//   RUN: each vld:
//     rt_comp  = ptch_rt - rt_offset            (RT_W+1 bits signed, no overflow)
//     az_comp  = AZ - AZ_OFFSET                 (RT_W+1 bits signed)
//     ptch_acc = (az_comp*ACC_GAIN) >>> ACC_SHIFT, truncated to RT_W signed
//     fuse     = !fuse_en ? 0 : (ptch_acc > ptch) ? +FUSE_STEP : -FUSE_STEP (ptch = current reg)
//     ptch_int <= sat_INT_W(ptch_int - sext(rt_comp) + fuse), sum formed in INT_W+2 bits;
//     clamp to [-2^(INT_W-1), 2^(INT_W-1)-1], never wraps.
//     ptch_vld <= 1 for exactly one cycle (latency 1 from vld); ptch updates same edge.
//   cal_req=1 (any state, checked every cycle, priority over vld): state<=CAL, cal_sum,
//     cal_cnt, ptch_int <= 0, cal_done<=0, ptch_vld<=0; rt_offset retained until new result.
//     Simultaneous vld sample discarded. Calibration counts from first vld after cal_req low.
//   vld outside CAL/RUN semantics: none (two-state FSM; illegal encoding -> CAL).
//   Async reset mid-calibration or mid-run returns to reset values immediately.
// STRUCTURE
//   Package inertial_pkg: typedef enum logic {CAL, RUN} integ_state_t; default
//     AZ_OFFSET/ACC_GAIN/FUSE_STEP localparams shared with the legacy integrator.
//   Sub-module sat_add (parametrised width, signed add with clamp) for the accumulator path.
//   FSM, calibration counter/sum and fusion compare stay in the top module.
// TESTING (bench uses CAL_LOG2=4, other defaults)
//   16 vlds ptch_rt=0x0050 after reset -> rt_offset=0x0050, cal_done rises cycle after 16th.
//   RUN, ptch_rt=0x0050, AZ=0x00A0, fuse_en=0, 100 vlds -> ptch=0, ptch_vld pulses 100x.
//   RUN, fuse_en=0, ptch_rt=0x0850 for 16 vlds -> ptch_int=-32768, ptch=-16 (0xFFF0).
//   RUN, fuse_en=1, ptch_rt=0x0050, AZ=0x04A0 (ptch_acc=47) 2 vlds -> ptch_int=2048, ptch=1.
//   RUN, fuse_en=0, ptch_rt=0x8000 continuously -> ptch ramps to 0x7FFF and holds, no wrap.
//   cal_req pulse with vld in RUN -> ptch=0, cal_done=0, no ptch_vld until 16 new vlds done.

Source files
------------

// File: rtl/inertial_pkg.sv
// inertial_pkg: shared state type and default tuning constants for the pitch integrators
package inertial_pkg;
  typedef enum logic {CAL, RUN} integ_state_t;
  localparam logic [15:0] DEF_AZ_OFFSET = 16'h00A0;
  localparam int          DEF_ACC_GAIN  = 377;
  localparam int          DEF_ACC_SHIFT = 13;
  localparam int          DEF_FUSE_STEP = 1024;
endpackage

// File: rtl/sat_add.sv
// sat_add: signed W-bit add that clamps to the W-bit range instead of wrapping
module sat_add #(
  parameter int W = 27
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] y_o
);
  logic signed [W+1:0] sum;
  logic                ovf;
  assign sum = (W+2)'(a_i) + (W+2)'(b_i);
  assign ovf = (sum[W+1:W-1] != 3'b000) && (sum[W+1:W-1] != 3'b111);
  assign y_o = !ovf ? sum[W-1:0] : sum[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
endmodule

// File: rtl/inertial_integrator_cal.sv
// inertial_integrator_cal: gyro pitch integrator with offset calibration and accel fusion
module inertial_integrator_cal
  import inertial_pkg::*;
#(
  parameter int                     RT_W      = 16,
  parameter int                     INT_W     = 27,
  parameter int                     CAL_LOG2  = 9,
  parameter logic signed [RT_W-1:0] AZ_OFFSET = DEF_AZ_OFFSET,
  parameter int                     ACC_GAIN  = DEF_ACC_GAIN,
  parameter int                     ACC_SHIFT = DEF_ACC_SHIFT,
  parameter int                     FUSE_STEP = DEF_FUSE_STEP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vld,
  input  logic signed [RT_W-1:0] ptch_rt,
  input  logic signed [RT_W-1:0] AZ,
  input  logic                   cal_req,
  input  logic                   fuse_en,
  output logic signed [RT_W-1:0] ptch,
  output logic                   ptch_vld,
  output logic                   cal_done,
  output logic signed [RT_W-1:0] rt_offset
);
  localparam int CW = RT_W + CAL_LOG2;
  localparam int PW = RT_W + ACC_SHIFT;

  integ_state_t             state_q, state_d;
  logic signed [CW-1:0]     cal_sum_q, cal_sum_d, cal_next;
  logic [CAL_LOG2-1:0]      cal_cnt_q, cal_cnt_d;
  logic signed [RT_W-1:0]   rt_offset_q, rt_offset_d;
  logic signed [INT_W-1:0]  ptch_int_q, ptch_int_d, int_step, int_sat;
  logic                     ptch_vld_q, ptch_vld_d;
  logic signed [RT_W:0]     rt_comp, az_comp;
  logic signed [PW-1:0]     prod;
  logic signed [RT_W-1:0]   ptch_acc, ptch_s;
  logic signed [INT_W-1:0]  fuse;

  assign ptch_s   = ptch_int_q[INT_W-1 -: RT_W];
  assign rt_comp  = (RT_W+1)'(ptch_rt) - (RT_W+1)'(rt_offset_q);
  assign az_comp  = (RT_W+1)'(AZ) - (RT_W+1)'(AZ_OFFSET);
  assign prod     = PW'(az_comp) * PW'(ACC_GAIN);
  assign ptch_acc = RT_W'(prod >>> ACC_SHIFT);
  assign fuse     = !fuse_en ? '0 : (ptch_acc > ptch_s) ? INT_W'(FUSE_STEP) : -INT_W'(FUSE_STEP);
  assign int_step = fuse - INT_W'(rt_comp);
  assign cal_next = cal_sum_q + CW'(ptch_rt);

  sat_add #(.W(INT_W)) u_sat (
    .a_i (ptch_int_q),
    .b_i (int_step),
    .y_o (int_sat)
  );

  // Next-state: cal_req overrides everything, then vld drives calibration or integration
  always_comb begin
    state_d     = state_q;
    cal_sum_d   = cal_sum_q;
    cal_cnt_d   = cal_cnt_q;
    rt_offset_d = rt_offset_q;
    ptch_int_d  = ptch_int_q;
    ptch_vld_d  = 1'b0;
    if (cal_req) begin
      state_d    = CAL;
      cal_sum_d  = '0;
      cal_cnt_d  = '0;
      ptch_int_d = '0;
    end else if (vld && state_q == RUN) begin
      ptch_int_d = int_sat;
      ptch_vld_d = 1'b1;
    end else if (vld) begin
      if (cal_cnt_q == '1) begin
        rt_offset_d = RT_W'(cal_next >>> CAL_LOG2);
        cal_sum_d   = '0;
        cal_cnt_d   = '0;
        ptch_int_d  = '0;
        state_d     = RUN;
      end else begin
        cal_sum_d = cal_next;
        cal_cnt_d = cal_cnt_q + CAL_LOG2'(1);
      end
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CAL;
      cal_sum_q   <= '0;
      cal_cnt_q   <= '0;
      rt_offset_q <= '0;
      ptch_int_q  <= '0;
      ptch_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cal_sum_q   <= cal_sum_d;
      cal_cnt_q   <= cal_cnt_d;
      rt_offset_q <= rt_offset_d;
      ptch_int_q  <= ptch_int_d;
      ptch_vld_q  <= ptch_vld_d;
    end
  end

  assign ptch      = ptch_s;
  assign ptch_vld  = ptch_vld_q;
  assign cal_done  = (state_q == RUN);
  assign rt_offset = rt_offset_q;
endmodule

// File: tb/tb_inertial_integrator_cal.sv
// tb_inertial_integrator_cal: directed checks of calibration, integration, fusion and saturation
module tb_inertial_integrator_cal;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vld = 1'b0;
  logic signed [15:0] ptch_rt = '0;
  logic signed [15:0] AZ = '0;
  logic               cal_req = 1'b0;
  logic               fuse_en = 1'b0;
  logic signed [15:0] ptch;
  logic               ptch_vld;
  logic               cal_done;
  logic signed [15:0] rt_offset;
  int n_cmp = 0;
  int n_err = 0;
  int pv_cnt = 0;

  inertial_integrator_cal #(.CAL_LOG2(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld),
    .ptch_rt   (ptch_rt),
    .AZ        (AZ),
    .cal_req   (cal_req),
    .fuse_en   (fuse_en),
    .ptch      (ptch),
    .ptch_vld  (ptch_vld),
    .cal_done  (cal_done),
    .rt_offset (rt_offset)
  );

  always #5 clk = ~clk;

  // Tally output strobes; each strobe is sampled on exactly one falling edge
  always @(negedge clk) if (ptch_vld === 1'b1) pv_cnt <= pv_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic vld_pulse(input logic [15:0] rt, input logic [15:0] az);
    @(negedge clk);
    ptch_rt = rt;
    AZ = az;
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    #1;
  endtask

  task automatic req_pulse(input logic with_vld);
    @(negedge clk);
    cal_req = 1'b1;
    vld = with_vld;
    @(negedge clk);
    cal_req = 1'b0;
    vld = 1'b0;
    #1;
  endtask

  task automatic vld_n(input int n, input logic [15:0] rt, input logic [15:0] az);
    for (int i = 0; i < n; i++) vld_pulse(rt, az);
  endtask

  initial begin
    int pv_base;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ptch", ptch, 16'h0000);
    chk("rst_ptch_vld", {15'd0, ptch_vld}, 16'h0000);
    chk("rst_cal_done", {15'd0, cal_done}, 16'h0000);
    chk("rst_rt_offset", rt_offset, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    vld_n(15, 16'h0050, 16'h00A0);
    chk("cal15_not_done", {15'd0, cal_done}, 16'h0000);
    vld_pulse(16'h0050, 16'h00A0);
    chk("cal16_done", {15'd0, cal_done}, 16'h0001);
    chk("cal16_offset", rt_offset, 16'h0050);
    chk("cal_no_strobe", 16'(pv_cnt), 16'd0);
    vld_n(100, 16'h0050, 16'h00A0);
    chk("run_zero_ptch", ptch, 16'h0000);
    chk("run_strobes", 16'(pv_cnt), 16'd100);
    @(negedge clk);
    #1;
    chk("strobe_one_cycle", {15'd0, ptch_vld}, 16'h0000);
    vld_n(8, 16'h0850, 16'h00A0);
    chk("rate_half", ptch, 16'hFFF8);
    vld_n(8, 16'h0850, 16'h00A0);
    chk("rate_full", ptch, 16'hFFF0);
    pv_base = pv_cnt;
    req_pulse(1'b1);
    chk("req_ptch", ptch, 16'h0000);
    chk("req_cal_done", {15'd0, cal_done}, 16'h0000);
    chk("req_keep_offset", rt_offset, 16'h0050);
    @(negedge clk);
    cal_req = 1'b1;
    vld_n(3, 16'h7000, 16'h00A0);
    cal_req = 1'b0;
    chk("req_held_cal", {15'd0, cal_done}, 16'h0000);
    vld_n(8, 16'h0010, 16'h00A0);
    vld_n(7, 16'hFFEF, 16'h00A0);
    chk("recal15_not_done", {15'd0, cal_done}, 16'h0000);
    chk("recal_offset_kept", rt_offset, 16'h0050);
    vld_pulse(16'hFFEF, 16'h00A0);
    chk("recal_done", {15'd0, cal_done}, 16'h0001);
    chk("recal_floor_avg", rt_offset, 16'hFFFF);
    chk("recal_no_strobe", 16'(pv_cnt - pv_base), 16'd0);
    req_pulse(1'b0);
    vld_n(16, 16'h0050, 16'h00A0);
    chk("cal3_offset", rt_offset, 16'h0050);
    fuse_en = 1'b1;
    vld_pulse(16'h0050, 16'h04A0);
    chk("fuse_up1", ptch, 16'h0000);
    vld_pulse(16'h0050, 16'h04A0);
    chk("fuse_up2", ptch, 16'h0001);
    vld_n(2, 16'h0050, 16'h00A0);
    chk("fuse_down_eq", ptch, 16'h0000);
    vld_pulse(16'h0050, 16'h00A0);
    chk("fuse_down_neg", ptch, 16'hFFFF);
    fuse_en = 1'b0;
    vld_n(64, 16'h8000, 16'h00A0);
    chk("ramp_mid", ptch, 16'h0402);
    vld_n(2036, 16'h8000, 16'h00A0);
    chk("ramp_sat", ptch, 16'h7FFF);
    vld_n(50, 16'h8000, 16'h00A0);
    chk("ramp_hold", ptch, 16'h7FFF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ptch", ptch, 16'h0000);
    chk("async_cal_done", {15'd0, cal_done}, 16'h0000);
    chk("async_offset", rt_offset, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
